serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter N, default 4, giving operand and sum width in bits (N >= 2).
REQ-002 The module SHALL use one clock; reset is synchronous and active-low.
REQ-003 The ports SHALL appear in this positional order: a, b, reset, load, clk, sum, cout.
REQ-004 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-005 Port reset: input, 1 bit, synchronous active-low reset (0 = reset).
REQ-006 Port a: input, N bits, operand A, sampled only on a load cycle.
REQ-007 Port b: input, N bits, operand B, sampled only on a load cycle.
REQ-008 Port load: input, 1 bit, active-high start; captures a/b and begins an addition.
REQ-009 Port sum: output, N bits, registered result A+B mod 2^N of the last completed addition.
REQ-010 Port cout: output, 1 bit, registered carry-out of the last completed addition.

Function
REQ-011 The adder SHALL be bit-serial: one full-adder cell plus a 1-bit carry flip-flop, LSB first, one bit per clock.
REQ-012 Internal state SHALL be operand shift registers RA and RB (N bits), result shift register RS (N bits), carry flop C, a bit counter of ceil(log2 N) bits, and a 2-state FSM IDLE/SHIFT.
REQ-013 In IDLE with load=1 at a rising edge, the block SHALL load RA<=a, RB<=b, C<=0, RS<=0, counter<=0, and go to SHIFT.
REQ-014 In IDLE with load=0, all state SHALL hold; sum and cout SHALL hold their last values.
REQ-015 Each SHIFT cycle SHALL compute s = RA[0]^RB[0]^C and c = majority(RA[0],RB[0],C).
REQ-016 Each SHIFT cycle SHALL shift RA and RB right by 1, shift s into RS MSB (RS <= {s, RS[N-1:1]}), set C<=c, and increment the counter.
REQ-017 On the SHIFT cycle with counter = N-1, the block SHALL write sum <= {s, RS[N-1:1]} and cout <= c, and return to IDLE.
REQ-018 Latency: for load sampled at edge k, sum and cout SHALL be valid after edge k+N and held until the next completion or reset.
REQ-019 During SHIFT, sum and cout SHALL keep the previous result and SHALL NOT show partial values.
REQ-020 load=1 during SHIFT SHALL abort the current addition and restart per REQ-013 with the new a/b; the aborted result SHALL never reach sum/cout.
REQ-021 Overflow: sum SHALL wrap modulo 2^N, and cout SHALL equal bit N of the true A+B.
REQ-022 a and b SHALL be ignored on every cycle except a load cycle.

Reset
REQ-023 With reset=0 at a rising edge, the block SHALL set sum=0, cout=0, FSM=IDLE, and clear RA, RB, RS, C and counter.
REQ-024 Reset SHALL take priority over load and over an in-progress addition.
REQ-025 An addition interrupted by reset SHALL be discarded; after reset deasserts, the block SHALL wait in IDLE for load.
REQ-026 Reset SHALL act only at clock edges; mid-cycle reset changes SHALL have no effect.

Verification
REQ-027 Bench: reset=0 for 1 cycle, then load a=1010, b=0111 (N=4) -> after 4 edges sum=0001, cout=1.
REQ-028 Bench: load a=0011, b=0100 -> after 4 edges sum=0111, cout=0; sum/cout unchanged during the 4 SHIFT cycles.
REQ-029 Bench: load a=1111, b=1111 -> sum=1110, cout=1; then load a=0000, b=0000 -> sum=0000, cout=0.
REQ-030 Bench: start 1010+0111, assert reset=0 at SHIFT cycle 2 -> sum=0000, cout=0; sum/cout stay 0 with no load.
REQ-031 Bench: start 1111+0001, re-load 0010+0011 at SHIFT cycle 2 -> 4 edges after the re-load sum=0101, cout=0; the value 0000/1 never appears.
REQ-032 Bench: N=8, exhaustive or random a/b with back-to-back loads every N+1 cycles -> {cout,sum} = a+b every time.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first, one bit per clock.
// sum/cout are updated only when an addition completes, so partial results never appear.
module serial_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         reset,
  input  logic         load,
  input  logic         clk,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_ra;
  logic [N-1:0]  w_ra_next;
  logic [N-1:0]  r_rb;
  logic [N-1:0]  w_rb_next;
  logic [N-1:0]  r_rs;
  logic [N-1:0]  w_rs_next;
  logic          r_c;
  logic          w_c_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [N-1:0]  r_sum;
  logic [N-1:0]  w_sum_next;
  logic          r_cout;
  logic          w_cout_next;

  logic          w_s;
  logic          w_c;
  logic [N-1:0]  w_rs_shifted;

  // The single full-adder cell.
  assign w_s          = r_ra[0] ^ r_rb[0] ^ r_c;
  assign w_c          = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_c) | (r_rb[0] & r_c);
  assign w_rs_shifted = {w_s, r_rs[N-1:1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rs    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ra    <= w_ra_next;
      r_rb    <= w_rb_next;
      r_rs    <= w_rs_next;
      r_c     <= w_c_next;
      r_cnt   <= w_cnt_next;
      r_sum   <= w_sum_next;
      r_cout  <= w_cout_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ra_next    = r_ra;
    w_rb_next    = r_rb;
    w_rs_next    = r_rs;
    w_c_next     = r_c;
    w_cnt_next   = r_cnt;
    w_sum_next   = r_sum;
    w_cout_next  = r_cout;

    // A load in either state (re)starts; an aborted addition simply never completes.
    if (load) begin
      w_state_next = SHIFT;
      w_ra_next    = a;
      w_rb_next    = b;
      w_rs_next    = '0;
      w_c_next     = 1'b0;
      w_cnt_next   = '0;
    end else if (r_state == SHIFT) begin
      w_ra_next  = {1'b0, r_ra[N-1:1]};
      w_rb_next  = {1'b0, r_rb[N-1:1]};
      w_rs_next  = w_rs_shifted;
      w_c_next   = w_c;
      w_cnt_next = r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        w_sum_next   = w_rs_shifted;
        w_cout_next  = w_c;
        w_state_next = IDLE;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at N=4 and N=8.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       load4 = 1'b0;
  logic [3:0] sum4;
  logic       cout4;
  logic [7:0] a8 = '0, b8 = '0;
  logic       load8 = 1'b0;
  logic [7:0] sum8;
  logic       cout8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.N(4)) dut4 (
    .a(a4), .b(b4), .reset(reset), .load(load4), .clk(clk), .sum(sum4), .cout(cout4)
  );

  serial_adder #(.N(8)) dut8 (
    .a(a8), .b(b8), .reset(reset), .load(load8), .clk(clk), .sum(sum8), .cout(cout8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t       vecs[7];
    logic [4:0] exp_prev;
    logic [8:0] exp8;

    vecs[0] = '{4'b1010, 4'b0111, 4'b0001, 1'b1};
    vecs[1] = '{4'b0011, 4'b0100, 4'b0111, 1'b0};
    vecs[2] = '{4'b1111, 4'b1111, 4'b1110, 1'b1};
    vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[4] = '{4'b1000, 4'b1000, 4'b0000, 1'b1};
    vecs[5] = '{4'b1001, 4'b0110, 4'b1111, 1'b0};
    vecs[6] = '{4'b0101, 4'b0101, 4'b1010, 1'b0};

    // One-cycle reset, with load asserted to show reset wins.
    reset = 1'b0;
    load4 = 1'b1;
    a4 = 4'hF;
    b4 = 4'hF;
    step();
    load4 = 1'b0;
    reset = 1'b1;
    check("reset_state", {4'b0, cout4, sum4}, 9'h000);
    exp_prev = 5'b0;

    for (int i = 0; i < 7; i++) begin
      load4 = 1'b1;
      a4 = vecs[i].a;
      b4 = vecs[i].b;
      step();
      load4 = 1'b0;
      // Operands must be ignored outside the load cycle.
      a4 = ~vecs[i].a;
      b4 = 4'b1011;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("hold_v%0d_c%0d", i, k), {4'b0, cout4, sum4}, {4'b0, exp_prev});
        step();
      end
      check($sformatf("result_v%0d", i), {4'b0, cout4, sum4},
            {4'b0, vecs[i].exp_cout, vecs[i].exp_sum});
      exp_prev = {vecs[i].exp_cout, vecs[i].exp_sum};
      step();
      check($sformatf("idle_hold_v%0d", i), {4'b0, cout4, sum4}, {4'b0, exp_prev});
    end

    // Reset in the middle of an addition discards it.
    load4 = 1'b1;
    a4 = 4'b1010;
    b4 = 4'b0111;
    step();
    load4 = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("reset_midadd", {4'b0, cout4, sum4}, 9'h000);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("post_reset_idle_%0d", k), {4'b0, cout4, sum4}, 9'h000);
    end

    // Re-load during SHIFT aborts 1111+0001 (0000/1 must never appear).
    load4 = 1'b1;
    a4 = 4'b1111;
    b4 = 4'b0001;
    step();
    load4 = 1'b0;
    check("abort_c0", {4'b0, cout4, sum4}, 9'h000);
    step();
    check("abort_c1", {4'b0, cout4, sum4}, 9'h000);
    load4 = 1'b1;
    a4 = 4'b0010;
    b4 = 4'b0011;
    step();
    load4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reload_hold_%0d", k), {4'b0, cout4, sum4}, 9'h000);
      step();
    end
    check("reload_hold_3", {4'b0, cout4, sum4}, 9'h000);
    step();
    check("reload_result", {4'b0, cout4, sum4}, 9'h005);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("reload_after_%0d", k), {4'b0, cout4, sum4}, 9'h005);
    end

    // A reset pulse between edges must have no effect.
    #2 reset = 1'b0;
    #3 reset = 1'b1;
    step();
    check("midcycle_reset", {4'b0, cout4, sum4}, 9'h005);

    // N=8: back-to-back loads every N+1 cycles.
    for (int t = 0; t < 40; t++) begin
      if (t == 0) begin
        a8 = 8'hFF;
        b8 = 8'hFF;
      end else if (t == 1) begin
        a8 = 8'h00;
        b8 = 8'h00;
      end else if (t == 2) begin
        a8 = 8'h80;
        b8 = 8'h80;
      end else begin
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
      end
      exp8 = {1'b0, a8} + {1'b0, b8};
      load8 = 1'b1;
      step();
      load8 = 1'b0;
      a8 = 8'h5A;
      b8 = 8'hC3;
      for (int k = 0; k < 8; k++) step();
      check($sformatf("n8_t%0d", t), {cout8, sum8}, exp8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
